cond_unit: RTL and testbench

- Consumer end of the ALU flag interface in the multicycle core.
- Holds the architectural NZCV flag register, fed from the 4-bit ALU flag bus {N,Z,C,V}.
- Evaluates the 4-bit condition field of the current instruction and latches the result for the instruction's later cycles.
- Gates the PC, register-file and memory write enables produced by the main FSM, and keeps a saturating count of condition-failed instructions for debug.

---
 rtl/cond_unit_pkg.sv | 27 ++
 rtl/cond_unit_check.sv | 39 +++
 rtl/cond_unit.sv | 64 ++++++
 tb/tb_cond_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_unit_pkg.sv
// Shared condition-code encodings and NZCV bit positions for the condition unit.
// Flag bit order matches the ALU flag bus {N,Z,C,V}.
package cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_check.sv
// Combinational condition evaluator: condition field plus NZCV flags -> pass/fail.
// The reserved 1111 encoding is treated as always.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condok
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        condok = 1'b1;
        case (cond)
            COND_EQ: condok = z;
            COND_NE: condok = ~z;
            COND_CS: condok = c;
            COND_CC: condok = ~c;
            COND_MI: condok = n;
            COND_PL: condok = ~n;
            COND_VS: condok = v;
            COND_VC: condok = ~v;
            COND_HI: condok = c & ~z;
            COND_LS: condok = ~c | z;
            COND_GE: condok = (n == v);
            COND_LT: condok = (n != v);
            COND_GT: condok = ~z & (n == v);
            COND_LE: condok = z | (n != v);
            default: condok = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Flag register, latched condition result and write-enable gating for the multicycle core.
// Also keeps a saturating count of condition-failed instructions for debug.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             CondLatch,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondEx,
    output logic [CNT_W-1:0] CondFailCnt
);

    logic condok;

    cond_check u_cond_check (
        .cond   (Cond),
        .flags  (Flags),
        .condok (condok)
    );

    // Flag writes are qualified by the CondEx value held before this edge,
    // so a same-cycle CondLatch cannot affect its own instruction's flag write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags       <= 4'b0000;
            CondEx      <= 1'b0;
            CondFailCnt <= '0;
        end else begin
            if (FlagW[1] && CondEx) begin
                Flags[FLAG_N] <= ALUFlags[FLAG_N];
                Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0] && CondEx) begin
                Flags[FLAG_C] <= ALUFlags[FLAG_C];
                Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
            if (CondLatch) begin
                CondEx <= condok;
            end
            if (CondLatch && !condok && (CondFailCnt != {CNT_W{1'b1}})) begin
                CondFailCnt <= CondFailCnt + CNT_W'(1);
            end
        end
    end

    // Reset kills write enables immediately, including the unconditional fetch increment.
    assign PCWrite  = ~reset & ((PCS & CondEx) | NextPC);
    assign RegWrite = ~reset & RegW & CondEx;
    assign MemWrite = ~reset & MemW & CondEx;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: reference condition table, flag model and
// saturating counter model feed expectation queues compared after each edge.
module tb_cond_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             CondLatch;
    logic             PCS;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic             CondEx;
    logic [CNT_W-1:0] CondFailCnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]       m_flags;
    logic             m_condex;
    logic [CNT_W-1:0] m_cnt;

    logic             exp_condex_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .Cond        (Cond),
        .ALUFlags    (ALUFlags),
        .FlagW       (FlagW),
        .CondLatch   (CondLatch),
        .PCS         (PCS),
        .NextPC      (NextPC),
        .RegW        (RegW),
        .MemW        (MemW),
        .PCWrite     (PCWrite),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .Flags       (Flags),
        .CondEx      (CondEx),
        .CondFailCnt (CondFailCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Cond = 4'd14; ALUFlags = 4'd0; FlagW = 2'b00; CondLatch = 1'b0;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
    endtask

    // Model update for a CondLatch on the coming edge; pushes expectations.
    task automatic model_latch(input logic [3:0] c);
        logic ok;
        ok = cond_ref(c, m_flags);
        if (!ok && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        exp_condex_q.push_back(ok);
        exp_cnt_q.push_back(m_cnt);
    endtask

    task automatic check_latch(input string name);
        logic e;
        logic [CNT_W-1:0] ec;
        e  = exp_condex_q.pop_front();
        ec = exp_cnt_q.pop_front();
        m_condex = e;
        n_tests++;
        if (CondEx !== e) begin
            n_fail++;
            $display("FAIL %s condex: got %b expected %b", name, CondEx, e);
        end
        n_tests++;
        if (CondFailCnt !== ec) begin
            n_fail++;
            $display("FAIL %s cnt: got %0d expected %0d", name, CondFailCnt, ec);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        idle();
        Cond = 4'd14; CondLatch = 1'b1;
        model_latch(4'd14);
        tick();
        check_latch("set_flags_al");
        idle();
        FlagW = 2'b11; ALUFlags = f;
        tick();
        m_flags = f;
        idle();
        n_tests++;
        if (Flags !== m_flags) begin
            n_fail++;
            $display("FAIL set_flags: got %b expected %b", Flags, m_flags);
        end
    endtask

    task automatic test_reset();
        set_flags(4'b1111);
        NextPC = 1'b1;
        #1;
        n_tests++;
        if (PCWrite !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_pcwrite: got %b expected 1", PCWrite);
        end
        #2 reset = 1'b1;
        #1;
        m_flags = 4'b0000; m_condex = 1'b0; m_cnt = '0;
        n_tests++;
        if (PCWrite !== 1'b0) begin
            n_fail++; $display("FAIL reset_pcwrite: got %b expected 0", PCWrite);
        end
        n_tests++;
        if (Flags !== m_flags || CondEx !== m_condex || CondFailCnt !== m_cnt) begin
            n_fail++;
            $display("FAIL reset_state: got flags=%b condex=%b cnt=%0d expected 0000 0 0",
                     Flags, CondEx, CondFailCnt);
        end
        #1 reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_eq_ne();
        set_flags(4'b0100);
        Cond = 4'd0; CondLatch = 1'b1;
        model_latch(4'd0);
        tick();
        check_latch("eq_latch");
        idle();
        RegW = 1'b1;
        #1;
        n_tests++;
        if (RegWrite !== 1'b1) begin
            n_fail++; $display("FAIL eq_regwrite: got %b expected 1", RegWrite);
        end
        idle();
        Cond = 4'd1; CondLatch = 1'b1;
        model_latch(4'd1);
        tick();
        check_latch("ne_latch");
        idle();
        RegW = 1'b1; MemW = 1'b1;
        #1;
        n_tests++;
        if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL ne_gating: got reg=%b mem=%b expected 0 0", RegWrite, MemWrite);
        end
        n_tests++;
        if (CondFailCnt !== CNT_W'(1)) begin
            n_fail++; $display("FAIL ne_cnt: got %0d expected 1", CondFailCnt);
        end
        idle();
    endtask

    task automatic test_split_flags();
        set_flags(4'b0000);
        ALUFlags = 4'b1111; FlagW = 2'b10;
        tick();
        n_tests++;
        if (Flags !== 4'b1100) begin
            n_fail++; $display("FAIL split_nz: got %b expected 1100", Flags);
        end
        ALUFlags = 4'b0000; FlagW = 2'b01;
        tick();
        n_tests++;
        if (Flags !== 4'b1100) begin
            n_fail++; $display("FAIL split_cv: got %b expected 1100", Flags);
        end
        ALUFlags = 4'b0011; FlagW = 2'b00;
        tick();
        n_tests++;
        if (Flags !== 4'b1100) begin
            n_fail++; $display("FAIL split_none: got %b expected 1100", Flags);
        end
        m_flags = 4'b1100;
        idle();
    endtask

    task automatic test_sweep();
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c); CondLatch = 1'b1;
                model_latch(4'(c));
                tick();
                check_latch($sformatf("sweep_c%0d_f%0d", c, f));
            end
            idle();
        end
    endtask

    task automatic test_hazard();
        set_flags(4'b0000);
        Cond = 4'd0; CondLatch = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0100;
        model_latch(4'd0);
        tick();
        m_flags = 4'b0100;
        check_latch("hazard_latch");
        n_tests++;
        if (Flags !== m_flags) begin
            n_fail++; $display("FAIL hazard_flags: got %b expected %b", Flags, m_flags);
        end
        idle();
        FlagW = 2'b11; ALUFlags = 4'b1011;
        tick();
        n_tests++;
        if (Flags !== m_flags) begin
            n_fail++; $display("FAIL hazard_ignored: got %b expected %b", Flags, m_flags);
        end
        idle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            Cond = 4'd1; CondLatch = 1'b1;
            model_latch(4'd1);
            tick();
            check_latch($sformatf("sat_%0d", i));
        end
        idle();
        n_tests++;
        if (CondFailCnt !== 4'hF) begin
            n_fail++; $display("FAIL sat_final: got %h expected f", CondFailCnt);
        end
        PCS = 1'b1; NextPC = 1'b0;
        #1;
        n_tests++;
        if (PCWrite !== 1'b0) begin
            n_fail++; $display("FAIL branch_fail_pc0: got %b expected 0", PCWrite);
        end
        NextPC = 1'b1;
        #1;
        n_tests++;
        if (PCWrite !== 1'b1) begin
            n_fail++; $display("FAIL branch_fail_pc1: got %b expected 1", PCWrite);
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        m_flags = '0; m_condex = 1'b0; m_cnt = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        test_reset();
        test_eq_ne();
        test_split_flags();
        test_sweep();
        test_hazard();
        test_saturation();
        n_tests++;
        if (exp_condex_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_condex_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
